// File: rtl/i2c_bus_monitor_pkg.sv
// Shared definitions for the I2C bus monitor.
//   i2c_state_e   : FSM state encoding (IDLE=0, BITS=1, ACK=2)
//   I2C_BYTE_W    : data bits per I2C byte
//   I2C_LINE_IDLE : released (pulled-up) line level, used as the reset value
//                   of the registered SCL/SDA copies
package i2c_bus_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } i2c_state_e;

  localparam int   I2C_BYTE_W    = 8;
  localparam logic I2C_LINE_IDLE = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bus-side bundle of the I2C bus monitor.
//   sclDebounced / sdaDebounced : filtered bus lines into the monitor
//   startDet, repStartDet, stopDet, busBusy, byteValid, byteData, ackBit,
//   addrByte, busTimeout        : decoded bus events out of the monitor
// Modports:
//   slave  : the monitor (consumes lines, produces events)
//   master : whoever drives the lines and consumes the events
interface i2c_bus_monitor_if;
  import i2c_bus_monitor_pkg::*;

  logic                  sclDebounced;
  logic                  sdaDebounced;
  logic                  startDet;
  logic                  repStartDet;
  logic                  stopDet;
  logic                  busBusy;
  logic                  byteValid;
  logic [I2C_BYTE_W-1:0] byteData;
  logic                  ackBit;
  logic                  addrByte;
  logic                  busTimeout;

  modport slave (
    input  sclDebounced, sdaDebounced,
    output startDet, repStartDet, stopDet, busBusy, byteValid,
           byteData, ackBit, addrByte, busTimeout
  );

  modport master (
    output sclDebounced, sdaDebounced,
    input  startDet, repStartDet, stopDet, busBusy, byteValid,
           byteData, ackBit, addrByte, busTimeout
  );
endinterface

// File: rtl/i2c_bus_monitor_line_edges.sv
// i2c_line_edges: registers SCL/SDA and flags bus conditions by comparing
// the registered (previous) value with the current input.
// Ports:
//   fastClock, resetN : clock, async active-low reset
//   scl, sda          : filtered bus lines
//   sclRise           : SCL went 0 -> 1
//   startCond         : SDA fell while SCL stayed high
//   stopCond          : SDA rose while SCL stayed high
module i2c_line_edges
  import i2c_bus_monitor_pkg::*;
(
  input  logic fastClock,
  input  logic resetN,
  input  logic scl,
  input  logic sda,
  output logic sclRise,
  output logic startCond,
  output logic stopCond
);

  logic scl_prev;
  logic sda_prev;

  always_ff @(posedge fastClock or negedge resetN) begin
    if (!resetN) begin
      scl_prev <= I2C_LINE_IDLE;
      sda_prev <= I2C_LINE_IDLE;
    end else begin
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  // START/STOP require SCL high in both samples, so an SDA change that
  // coincides with an SCL change can only ever count as a rise.
  assign sclRise   = ~scl_prev & scl;
  assign startCond = scl_prev & scl & sda_prev & ~sda;
  assign stopCond  = scl_prev & scl & ~sda_prev & sda;

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: decodes filtered SCL/SDA into START, repeated START, STOP,
// bus-busy and assembled bytes with their ACK bit.
// Ports:
//   fastClock, resetN : clock, async active-low reset
//   bus (slave)       : lines in, registered event outputs out
// Optional stuck-bus timeout: define I2C_BUS_TIMEOUT_EN. Without it no
// counter exists and busTimeout is tied low.
module i2c_bus_monitor
  import i2c_bus_monitor_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          TIMEOUT_W      = 16
) (
  input  logic           fastClock,
  input  logic           resetN,
  i2c_bus_monitor_if.slave bus
);

  logic scl_rise, start_cond, stop_cond, timeout_hit;

  i2c_line_edges u_edges (
    .fastClock (fastClock),
    .resetN    (resetN),
    .scl       (bus.sclDebounced),
    .sda       (bus.sdaDebounced),
    .sclRise   (scl_rise),
    .startCond (start_cond),
    .stopCond  (stop_cond)
  );

  i2c_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  first_q, first_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d, rep_q, rep_d, stop_q, stop_d;
  logic                  valid_q, valid_d, ack_q, ack_d, addr_q, addr_d;
  logic [I2C_BYTE_W-1:0] byte_q, byte_d;
  logic                  tout_q, tout_d;

`ifdef I2C_BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tout_cnt;

  always_ff @(posedge fastClock or negedge resetN) begin
    if (!resetN)
      tout_cnt <= '0;
    else if (bus.sclDebounced || timeout_hit)
      tout_cnt <= '0;
    else if (busy_q)
      tout_cnt <= tout_cnt + 1'b1;
  end

  assign timeout_hit = busy_q & ~bus.sclDebounced &
                       (tout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 16'd1));
`else
  // Keeps the timeout parameters referenced in builds without the counter.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_W};
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge fastClock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      rep_q   <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= 1'b0;
      byte_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      rep_q   <= rep_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      tout_q  <= tout_d;
    end
  end

  // START/STOP need SCL high and timeout needs SCL low, so the first three
  // branches are mutually exclusive; a rise never coincides with START/STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    first_d = first_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    rep_d   = 1'b0;
    stop_d  = 1'b0;
    valid_d = 1'b0;
    ack_d   = ack_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    tout_d  = tout_q;

    if (stop_cond) begin
      stop_d  = 1'b1;
      busy_d  = 1'b0;
      first_d = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (start_cond) begin
      start_d = 1'b1;
      rep_d   = busy_q;
      busy_d  = 1'b1;
      first_d = 1'b1;
      tout_d  = 1'b0;
      cnt_d   = '0;
      state_d = BITS;
    end else if (timeout_hit) begin
      tout_d  = 1'b1;
      busy_d  = 1'b0;
      first_d = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        BITS: begin
          shift_d = {shift_q[I2C_BYTE_W-2:0], bus.sdaDebounced};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(I2C_BYTE_W - 1))
            state_d = ACK;
        end
        ACK: begin
          ack_d   = bus.sdaDebounced;
          byte_d  = shift_q;
          valid_d = 1'b1;
          addr_d  = first_q;
          first_d = 1'b0;
          cnt_d   = '0;
          state_d = BITS;
        end
        default: ;
      endcase
    end
  end

  assign bus.startDet    = start_q;
  assign bus.repStartDet = rep_q;
  assign bus.stopDet     = stop_q;
  assign bus.busBusy     = busy_q;
  assign bus.byteValid   = valid_q;
  assign bus.byteData    = byte_q;
  assign bus.ackBit      = ack_q;
  assign bus.addrByte    = addr_q;
  assign bus.busTimeout  = tout_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: drives bus transactions, keeps a
// transaction-level expectation (events and byte list) and compares it with
// what a monitor process collects from the DUT outputs.
module tb_i2c_bus_monitor;

  logic fastClock = 1'b0;
  logic resetN    = 1'b0;

  i2c_bus_monitor_if bus ();

  i2c_bus_monitor #(.TIMEOUT_CYCLES(16'd100), .TIMEOUT_W(16)) dut (
    .fastClock (fastClock),
    .resetN    (resetN),
    .bus       (bus)
  );

  always #5 fastClock = ~fastClock;

  int n_checks = 0;
  int n_pass   = 0;

  // transaction-level expectation
  bit         m_busy  = 1'b0;
  bit         m_first = 1'b0;
  logic [7:0] m_last  = 8'h00;
  int exp_start = 0, exp_rep = 0, exp_stop = 0;
  logic [9:0] exp_q[$];   // {addrByte, ackBit, byteData}

  // observed
  int got_start = 0, got_rep = 0, got_stop = 0, got_rep_lone = 0;
  logic [9:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge fastClock) begin
    if (bus.startDet) got_start++;
    if (bus.repStartDet && bus.startDet) got_rep++;
    if (bus.repStartDet && !bus.startDet) got_rep_lone++;
    if (bus.stopDet) got_stop++;
    if (bus.byteValid) got_q.push_back({bus.addrByte, bus.ackBit, bus.byteData});
  end

  task automatic line(input logic scl, input logic sda);
    @(negedge fastClock);
    bus.sclDebounced = scl;
    bus.sdaDebounced = sda;
    repeat ($urandom_range(0, 2)) @(negedge fastClock);
  endtask

  task automatic bus_start();
    if (bus.sclDebounced == 1'b0) begin
      line(1'b0, 1'b1);
      line(1'b1, 1'b1);
    end
    line(1'b1, 1'b0);
    line(1'b0, 1'b0);
    exp_start++;
    if (m_busy) exp_rep++;
    m_busy  = 1'b1;
    m_first = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    line(1'b0, b);
    line(1'b1, b);
    line(1'b0, b);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(a);
    exp_q.push_back({m_first, a, d});
    m_first = 1'b0;
    m_last  = d;
  endtask

  task automatic bus_stop();
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    line(1'b1, 1'b1);
    exp_stop++;
    m_busy  = 1'b0;
    m_first = 1'b0;
  endtask

  task automatic scoreboard(input string tag);
    repeat (3) @(negedge fastClock);
    #1;
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    chk({tag, "_starts"}, got_start, exp_start);
    chk({tag, "_repstarts"}, got_rep, exp_rep);
    chk({tag, "_rep_alone"}, got_rep_lone, 0);
    chk({tag, "_stops"}, got_stop, exp_stop);
    chk({tag, "_busy"}, 32'(bus.busBusy), 32'(m_busy));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_startDet"}, 32'(bus.startDet), 0);
    chk({tag, "_repStartDet"}, 32'(bus.repStartDet), 0);
    chk({tag, "_stopDet"}, 32'(bus.stopDet), 0);
    chk({tag, "_busBusy"}, 32'(bus.busBusy), 0);
    chk({tag, "_byteValid"}, 32'(bus.byteValid), 0);
    chk({tag, "_byteData"}, 32'(bus.byteData), 0);
    chk({tag, "_ackBit"}, 32'(bus.ackBit), 0);
    chk({tag, "_addrByte"}, 32'(bus.addrByte), 0);
    chk({tag, "_busTimeout"}, 32'(bus.busTimeout), 0);
  endtask

  initial begin
    int nb, np;
    bus.sclDebounced = 1'b1;
    bus.sdaDebounced = 1'b1;
    repeat (3) @(negedge fastClock);
    #1 check_reset_outputs("reset");
    @(negedge fastClock);
    resetN = 1'b1;

    // single address byte with ACK
    bus_start();
    chk("t1_busy_after_start", 32'(bus.busBusy), 1);
    send_byte(8'hA5, 1'b0);
    bus_stop();
    scoreboard("t1");

    // NACKed byte, repeated START, ACKed byte
    bus_start();
    send_byte(8'h3C, 1'b1);
    bus_start();
    send_byte(8'h81, 1'b0);
    bus_stop();
    scoreboard("t2");

    // partial byte aborted by STOP keeps the last byte
    bus_start();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    bus_stop();
    scoreboard("t3");
    chk("t3_byte_held", 32'(bus.byteData), 32'(m_last));

    // SCL and SDA toggling together never forms START/STOP
    for (int i = 0; i < 4; i++) begin
      line(1'b0, 1'b0);
      line(1'b1, 1'b1);
    end
    scoreboard("t4");

`ifdef I2C_BUS_TIMEOUT_EN
    line(1'b1, 1'b0);
    exp_start++;
    m_busy = 1'b1;
    @(negedge fastClock);
    bus.sclDebounced = 1'b0;
    repeat (99) @(negedge fastClock);
    #1 chk("t5_timeout_early", 32'(bus.busTimeout), 0);
    @(negedge fastClock);
    #1 chk("t5_timeout_set", 32'(bus.busTimeout), 1);
    chk("t5_busy_dropped", 32'(bus.busBusy), 0);
    m_busy  = 1'b0;
    m_first = 1'b0;
    line(1'b0, 1'b1);
    line(1'b1, 1'b1);
    bus_start();
    chk("t5_timeout_cleared", 32'(bus.busTimeout), 0);
    send_byte(8'h5A, 1'b0);
    bus_stop();
    scoreboard("t5");
`endif

    // reset during bit 4, then a clean byte
    bus_start();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    line(1'b0, 1'b1);
    line(1'b1, 1'b1);
    @(negedge fastClock);
    resetN = 1'b0;
    #1 check_reset_outputs("t6_reset");
    m_busy  = 1'b0;
    m_first = 1'b0;
    bus.sclDebounced = 1'b1;
    bus.sdaDebounced = 1'b1;
    repeat (2) @(negedge fastClock);
    resetN = 1'b1;
    bus_start();
    send_byte(8'($urandom), 1'($urandom));
    bus_stop();
    scoreboard("t6");

    // randomized transactions
    for (int it = 0; it < 15; it++) begin
      bus_start();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        if (b > 0 && $urandom_range(0, 3) == 0) bus_start();
        send_byte(8'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        np = int'($urandom_range(1, 6));
        for (int k = 0; k < np; k++) send_bit(1'($urandom));
      end
      bus_stop();
      scoreboard($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
